// File: rtl/conv_pw_seq_if.sv
// rtl/conv_pw_seq_if.sv - pixel in/out and weight-write handshake bundle for conv_pw_seq
interface conv_pw_seq_if #(
  parameter int IN_CH  = 8,
  parameter int OUT_CH = 16,
  parameter int ACT_W  = 8,
  parameter int W_W    = 2,
  parameter int BIAS_W = 8
);
  localparam int AW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [IN_CH*ACT_W-1:0]  in_act;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_CH*ACT_W-1:0] out_act;
  logic                    wr_en;
  logic                    wr_ready;
  logic [AW-1:0]           wr_addr;
  logic [IN_CH*W_W-1:0]    wr_weights;
  logic [BIAS_W-1:0]       wr_bias;

  modport master (
    output in_valid, in_act, out_ready, wr_en, wr_addr, wr_weights, wr_bias,
    input  in_ready, out_valid, out_act, wr_ready
  );

  modport slave (
    input  in_valid, in_act, out_ready, wr_en, wr_addr, wr_weights, wr_bias,
    output in_ready, out_valid, out_act, wr_ready
  );
endinterface

// File: rtl/conv_pw_seq.sv
// rtl/conv_pw_seq.sv - time-multiplexed 1x1 conv, PAR_OUT channels per cycle, shift + ReLU6
// Optional stall counter port enabled by CONV_PW_SEQ_STALL_CNT_EN.
module conv_pw_seq #(
  parameter int IN_CH   = 8,
  parameter int OUT_CH  = 16,
  parameter int PAR_OUT = 4,
  parameter int ACT_W   = 8,
  parameter int W_W     = 2,
  parameter int BIAS_W  = 8,
  parameter int ACC_W   = 32,
  parameter int SHIFT   = 1,
  parameter int CLAMP   = 6
) (
  input  logic         clk,
  input  logic         rstn,
`ifdef CONV_PW_SEQ_STALL_CNT_EN
  output logic [15:0]  stall_cnt,
`endif
  conv_pw_seq_if.slave bus
);
  localparam int G  = OUT_CH / PAR_OUT;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int AW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           g_q;
  logic [IN_CH*ACT_W-1:0]  x_q;
  logic [OUT_CH*ACT_W-1:0] out_q;
  logic [IN_CH*W_W-1:0]    w_mem [OUT_CH];
  logic [BIAS_W-1:0]       b_mem [OUT_CH];
  logic [ACT_W-1:0]        res   [PAR_OUT];
  logic signed [ACC_W-1:0] acc, r;
  logic [AW-1:0]           k;
  logic                    last_grp;
  logic                    wr_ok;

  assign last_grp     = (g_q == GW'(G - 1));
  assign wr_ok        = (state_q != BUSY);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.wr_ready  = wr_ok;
  assign bus.out_act   = out_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (last_grp)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One group of PAR_OUT channels per cycle; negative sums clamp to zero before the shift.
  always_comb begin
    acc = '0;
    r   = '0;
    k   = '0;
    for (int p = 0; p < PAR_OUT; p++) res[p] = '0;
    for (int p = 0; p < PAR_OUT; p++) begin
      k   = AW'(int'(g_q) * PAR_OUT + p);
      acc = ACC_W'(signed'(b_mem[k]));
      for (int c = 0; c < IN_CH; c++) begin
        acc = acc + ACC_W'(signed'(w_mem[k][c*W_W +: W_W]))
                  * ACC_W'(signed'(x_q[c*ACT_W +: ACT_W]));
      end
      r = acc >>> SHIFT;
      if (acc < 0)                res[p] = '0;
      else if (r > ACC_W'(CLAMP)) res[p] = ACT_W'(CLAMP);
      else                        res[p] = r[ACT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      g_q   <= '0;
      x_q   <= '0;
      out_q <= '0;
      for (int i = 0; i < OUT_CH; i++) begin
        w_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else begin
      if (state_q == IDLE && bus.in_valid) begin
        x_q <= bus.in_act;
        g_q <= '0;
      end
      if (state_q == BUSY) begin
        g_q <= last_grp ? '0 : g_q + 1'b1;
        for (int p = 0; p < PAR_OUT; p++)
          out_q[(int'(g_q) * PAR_OUT + p) * ACT_W +: ACT_W] <= res[p];
      end
      // Writes while BUSY are dropped rather than queued.
      if (bus.wr_en && wr_ok && int'(bus.wr_addr) < OUT_CH) begin
        w_mem[bus.wr_addr] <= bus.wr_weights;
        b_mem[bus.wr_addr] <= bus.wr_bias;
      end
    end
  end

`ifdef CONV_PW_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= '0;
    else if (bus.out_valid && !bus.out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_conv_pw_seq.sv
// tb/tb_conv_pw_seq.sv - scoreboard bench for conv_pw_seq with directed vectors
module tb_conv_pw_seq;
  localparam int IN_CH = 8, OUT_CH = 16, ACT_W = 8, W_W = 2, BIAS_W = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  conv_pw_seq_if #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .ACT_W(ACT_W), .W_W(W_W), .BIAS_W(BIAS_W)) bus ();

`ifdef CONV_PW_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  conv_pw_seq dut (
    .clk       (clk),
    .rstn      (rstn),
`ifdef CONV_PW_SEQ_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] exp_q [$];

  task automatic check1(string name, logic act, logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic check128(string name, logic [127:0] act, logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic timeout(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  function automatic logic [127:0] fill_out(logic [7:0] v);
    logic [127:0] t;
    for (int i = 0; i < 16; i++) t[i*8 +: 8] = v;
    return t;
  endfunction

  function automatic logic [63:0] fill_in(logic [7:0] v);
    logic [63:0] t;
    for (int i = 0; i < 8; i++) t[i*8 +: 8] = v;
    return t;
  endfunction

  // Monitor: every output handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rstn && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h required none", bus.out_act);
      end else begin
        check128("out_act", bus.out_act, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) timeout(name);
  endtask

  task automatic write_row(int a, logic [15:0] w, logic [7:0] b);
    int n = 0;
    while (!bus.wr_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.wr_ready) timeout("wr_ready_wait");
    bus.wr_en      = 1'b1;
    bus.wr_addr    = 4'(a);
    bus.wr_weights = w;
    bus.wr_bias    = b;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic send(logic [63:0] x, logic [127:0] e, bit push);
    wait_idle("in_ready_wait");
    bus.in_act   = x;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    if (push) exp_q.push_back(e);
  endtask

  initial begin
    logic [127:0] e;
    int n;
    bus.in_valid   = 1'b0;
    bus.in_act     = '0;
    bus.out_ready  = 1'b1;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_weights = '0;
    bus.wr_bias    = '0;
    tick();
    tick();
    check1("rst_in_ready", bus.in_ready, 1'b1);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_wr_ready", bus.wr_ready, 1'b1);
    check128("rst_out_act", bus.out_act, '0);
    rstn = 1'b1;
    tick();

    // Basic MAC with latency probe: 8 * 1 * 1 = 8, >>> 1 = 4.
    for (int a = 0; a < 16; a++) write_row(a, 16'h5555, 8'h00);
    send(fill_in(8'd1), fill_out(8'd4), 1'b1);
    check1("busy_wr_ready", bus.wr_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check1("latency_early", bus.out_valid, 1'b0);
      tick();
    end
    check1("latency_early", bus.out_valid, 1'b0);
    tick();
    check1("latency_e4", bus.out_valid, 1'b1);
    check1("done_wr_ready", bus.wr_ready, 1'b1);
    wait_idle("idle_basic");

    // Clamp: 8 * 10 = 80 -> 40 -> 6.
    send(fill_in(8'd10), fill_out(8'd6), 1'b1);
    wait_idle("idle_clamp");

    // Negative: 8 * -1 * 5 = -40 -> 0.
    for (int a = 0; a < 16; a++) write_row(a, 16'hFFFF, 8'h00);
    send(fill_in(8'd5), fill_out(8'd0), 1'b1);
    wait_idle("idle_neg");

    // Bias only: ch3 = 3 >>> 1 = 1, ch5 = -2 -> 0.
    for (int a = 0; a < 16; a++)
      write_row(a, 16'h0000, (a == 3) ? 8'd3 : (a == 5) ? 8'hFE : 8'h00);
    e = fill_out(8'd0);
    e[3*8 +: 8] = 8'd1;
    send(fill_in(8'd7), e, 1'b1);
    wait_idle("idle_bias");

    // Backpressure for 10 cycles with in_valid held high.
    for (int a = 0; a < 16; a++) write_row(a, 16'h5555, 8'h00);
    wait_idle("idle_bp_pre");
    bus.out_ready = 1'b0;
    bus.in_act    = fill_in(8'd1);
    bus.in_valid  = 1'b1;
    tick();
    exp_q.push_back(fill_out(8'd4));
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.out_valid) timeout("bp_out_valid");
    for (int i = 0; i < 10; i++) begin
      tick();
      check128("bp_stable", bus.out_act, fill_out(8'd4));
      check1("bp_in_ready", bus.in_ready, 1'b0);
    end
`ifdef CONV_PW_SEQ_STALL_CNT_EN
    check128("stall_cnt", {112'b0, stall_cnt}, 128'(10));
`endif
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check1("bp_idle", bus.in_ready, 1'b1);
    check1("bp_out_valid_low", bus.out_valid, 1'b0);

    // Write during BUSY must be dropped; row 0 stays zero for this and the next pixel.
    write_row(0, 16'h0000, 8'h00);
    e = fill_out(8'd4);
    e[7:0] = 8'd0;
    send(fill_in(8'd1), e, 1'b1);
    bus.wr_en      = 1'b1;
    bus.wr_addr    = 4'd0;
    bus.wr_weights = 16'h5555;
    bus.wr_bias    = 8'h00;
    check1("busy_wr_drop_ready", bus.wr_ready, 1'b0);
    tick();
    bus.wr_en = 1'b0;
    wait_idle("idle_wr_busy");
    send(fill_in(8'd1), e, 1'b1);
    wait_idle("idle_wr_busy2");

    // Reset at g=2: pixel lost, weights cleared.
    send(fill_in(8'd1), '0, 1'b0);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check1("rst_mid_out_valid", bus.out_valid, 1'b0);
    check1("rst_mid_in_ready", bus.in_ready, 1'b1);
    tick();
    rstn = 1'b1;
    tick();
`ifdef CONV_PW_SEQ_STALL_CNT_EN
    check128("stall_cnt_rst", {112'b0, stall_cnt}, 128'(0));
`endif
    send(fill_in(8'd1), fill_out(8'd0), 1'b1);
    wait_idle("idle_post_rst");
    tick();
    tick();
    check1("scoreboard_drained", exp_q.size() == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
